alu_nibble_seq: RTL and testbench
=================================

// Module: alu_nibble_seq
// PURPOSE
//   Multi-cycle ALU controller that performs WIDTH-bit add/subtract on one shared 4-bit adder_283.
//   It processes one nibble per clock, LSB nibble first, and latches the nibble carry between steps.
//   Sits between the control-word decoder (op/start) and the A/B registers/flags register in the CPU.
//   Mirrors the hardware build, which has one 74HC283 time-multiplexed by the microsequencer.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; must be a multiple of 4, >= 4
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      request; accepted only in IDLE
//   op         in   2      00 ADD, 01 ADC, 10 SUB, 11 SBC; sampled with start
//   a          in   WIDTH  operand A; sampled with start
//   b          in   WIDTH  operand B; sampled with start
//   c_in       in   1      carry flag input for ADC/SBC; sampled with start
//   busy       out  1      high from the cycle after acceptance until valid is deasserted
//   valid      out  1      one-cycle pulse: result/flags are final
//   result     out  WIDTH  sum/difference; holds its value until the next valid
//   flag_c     out  1      carry out (SUB/SBC: 1 = no borrow)
//   flag_z     out  1      result == 0
//   flag_n     out  1      result[WIDTH-1]
//   flag_v     out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//   - States: IDLE -> CALC (NIB = WIDTH/4 cycles) -> DONE (1 cycle) -> IDLE.
//   - Accept (IDLE and start=1): latch a, b' = SUB/SBC ? ~b : b, and carry.
//     Carry = ADD:0, ADC:c_in, SUB:1, SBC:c_in. Go to CALC with nibble index 0.
//   - CALC step i: adder a=a_r[4i+3:4i], b=b'_r[4i+3:4i], cin=carry_r.
//     Write the sum to the result nibble i; carry_r <= cout. After step NIB-1, go to DONE.
//   - DONE: valid=1, busy=1; flags are registered from the final result and carry_r.
//     The next cycle returns to IDLE.
//   - Latency: valid is asserted NIB+1 cycles after the accepting edge (WIDTH=8: 3 cycles).
//   - start while busy, or in the DONE cycle, is ignored and not queued.
//   - Operand/op changes after acceptance have no effect.
//   - Arithmetic is modulo 2^WIDTH. Carry is the carry out of the top nibble only.
//   - Reset (asynchronous, any state, including mid-CALC):
//     state=IDLE; busy=0; valid=0; result=0; all flags=0; internal registers=0.
//   - Outputs are glitch-free registers; no combinational path from inputs to outputs.
// CONFIGURATION
//   ALU_SEQ_OVF_EN defined:
//     flag_v = (a_r[MSB] == b'_r[MSB]) && (result[MSB] != a_r[MSB]), registered in DONE.
//   ALU_SEQ_OVF_EN undefined:
//     flag_v is tied to 0, and no overflow logic or register is generated.
// STRUCTURE
//   - Shared package alu_seq_pkg:
//     op enum (OP_ADD/OP_ADC/OP_SUB/OP_SBC).
//     state enum (S_IDLE/S_CALC/S_DONE).
//     localparam NIB = WIDTH/4 and nibble-index width $clog2(NIB) (min 1).
//   - One sub-module instance: adder_283, the existing 4-bit adder, as the sole arithmetic element.
//   - No second adder and no full-width '+' operator.
//   - Nibble select is an indexed part-select driven by the step counter.
// TESTING (WIDTH=8, both with and without ALU_SEQ_OVF_EN)
//   1. ADD 0x3A+0x47 -> result 0x81, C=0, Z=0, N=1, V=1 (0 without macro); valid 3 cycles after accept.
//   2. ADD 0xFF+0x01 -> result 0x00, C=1, Z=1, N=0, V=0.
//   3. ADC 0x0F+0x00, c_in=1 -> 0x10, C=0; proves the inter-nibble carry latch.
//   4. SUB 0x10-0x01 -> 0x0F, C=1; SBC 0x00-0x00 with c_in=0 -> 0xFF, C=0, N=1.
//   5. Pulse start with a new op during CALC -> ignored.
//      The first result is unchanged; busy never drops early; exactly one valid pulse.
//   6. rst_n low during CALC step 1 -> immediately busy=0, valid=0, result=0, flags=0.
//      After release, a new ADD 0x01+0x01 -> 0x02.
//   Also run an exhaustive loop of all op x a x b x c_in combinations against a reference model.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int nib_of(input int width);
    return width / 4;
  endfunction

  // Step counter needs at least one bit even for a single-nibble datapath.
  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

  localparam int NIB   = nib_of(DEF_WIDTH);
  localparam int NIB_W = idx_w(NIB);

endpackage

// File: rtl/adder_283.sv
// 4-bit carry-lookahead adder, gate-for-gate equivalent of the 74HC283.
module adder_283 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a single adder_283.
// Define ALU_SEQ_OVF_EN to build the signed-overflow flag; otherwise flag_v is tied low.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NSTEP = nib_of(WIDTH);
  localparam int IW    = idx_w(NSTEP);
  localparam logic [IW-1:0] LAST = IW'(NSTEP - 1);

  state_e           state, state_nx;
  logic [WIDTH-1:0] a_r, bp_r, res_r;
  logic             carry_r;
  logic [IW-1:0]    idx_r;

  logic             accept, last_step;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  adder_283 u_add (
    .a    (a_r[4*idx_r +: 4]),
    .b    (bp_r[4*idx_r +: 4]),
    .cin  (carry_r),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // Subtraction is a + ~b + carry, so borrow-in maps to carry-in = 0.
  always_comb begin
    b_eff   = b;
    cin_eff = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_eff = b;  cin_eff = 1'b0; end
      OP_ADC: begin b_eff = b;  cin_eff = c_in; end
      OP_SUB: begin b_eff = ~b; cin_eff = 1'b1; end
      OP_SBC: begin b_eff = ~b; cin_eff = c_in; end
      default: begin b_eff = b; cin_eff = 1'b0; end
    endcase
  end

  // busy stays high through the valid cycle, which blocks acceptance there.
  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    last_step = (idx_r == LAST);
    case (state)
      S_IDLE: if (start && !busy) begin
        accept   = 1'b1;
        state_nx = S_CALC;
      end
      S_CALC: if (last_step) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      bp_r    <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else if (accept) begin
      a_r     <= a;
      bp_r    <= b_eff;
      res_r   <= '0;
      carry_r <= cin_eff;
      idx_r   <= '0;
    end else if (state == S_CALC) begin
      res_r[4*idx_r +: 4] <= nib_sum;
      carry_r             <= nib_cout;
      idx_r               <= last_step ? '0 : idx_r + 1'b1;
    end
  end

  // result/flags only move on the DONE edge so they hold between valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      busy  <= accept || (state == S_CALC) || (state == S_DONE);
      valid <= (state == S_DONE);
      if (state == S_DONE) begin
        result <= res_r;
        flag_c <= carry_r;
        flag_z <= (res_r == '0);
        flag_n <= res_r[WIDTH-1];
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic v_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      v_r <= 1'b0;
    else if (state == S_DONE)
      v_r <= (a_r[WIDTH-1] == bp_r[WIDTH-1]) && (res_r[WIDTH-1] != a_r[WIDTH-1]);
  end

  assign flag_v = v_r;
`else
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Randomized and directed checks of alu_nibble_seq (WIDTH=8) against an arithmetic model.
module tb_alu_nibble_seq;

  localparam int W   = 8;
  localparam int NIB = W / 4;

`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0;
  logic         busy, valid, flag_c, flag_z, flag_n, flag_v;
  logic [W-1:0] result;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] obs;

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .valid(valid), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] cur_out();
    return {flag_c, flag_z, flag_n, flag_v, result};
  endfunction

  // Packed {C,Z,N,V,result} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [1:0] o, input logic [7:0] x,
                                          input logic [7:0] y, input logic ci);
    int ua, ub, sa, sb, s, sr, bor;
    logic c, v;
    logic [7:0] r;
    ua = x; ub = y;
    sa = $signed(x); sb = $signed(y);
    if (o < 2) begin
      bor = (o == 2'd1) ? int'(ci) : 0;
      s   = ua + ub + bor;
      sr  = sa + sb + bor;
      c   = (s > 255);
    end else begin
      bor = (o == 2'd2) ? 0 : 1 - int'(ci);
      s   = ua - ub - bor;
      sr  = sa - sb - bor;
      c   = (s >= 0);
    end
    r = s[7:0];
    v = OVF && (sr > 127 || sr < -128);
    return {c, r == 8'h00, r[7], v, r};
  endfunction

  // One transaction; poke keeps start asserted with different operands while busy.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] xa,
                       input logic [7:0] xb, input logic xc, input bit poke);
    int  lat, vcnt, bcnt;
    bit  busy_ok, held;
    @(negedge clk);
    op = o; a = xa; b = xb; c_in = xc; start = 1'b1;
    @(posedge clk); #1;
    if (poke) begin
      op = ~o; a = ~xa; b = xb + 8'd1; c_in = ~xc;
    end else start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!valid && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    obs = cur_out();
    chk({tag, "_lat"}, lat, NIB + 1);
    chk({tag, "_busy_calc"}, busy_ok, 1'b1);
    chk({tag, "_busy_valid"}, busy, 1'b1);
    vcnt = 0; bcnt = 0; held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
      if (busy) bcnt++;
      if (cur_out() !== obs) held = 1'b0;
    end
    chk({tag, "_extra_valid"}, vcnt, 0);
    chk({tag, "_busy_drop"}, bcnt, 0);
    chk({tag, "_hold"}, held, 1'b1);
  endtask

  initial begin
    logic [1:0] ro;
    logic [7:0] ra, rb;
    logic       rc;

    #1;
    chk("reset_state", {busy, valid, cur_out()}, 14'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("add_3a_47", 2'b00, 8'h3A, 8'h47, 1'b0, 1'b0);
    chk("add_3a_47_out", obs, {1'b0, 1'b0, 1'b1, OVF, 8'h81});
    do_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 1'b1, 1'b0);
    chk("add_ff_01_out", obs, {4'b1100, 8'h00});
    do_op("adc_0f_00", 2'b01, 8'h0F, 8'h00, 1'b1, 1'b0);
    chk("adc_0f_00_out", obs, {4'b0000, 8'h10});
    do_op("sub_10_01", 2'b10, 8'h10, 8'h01, 1'b0, 1'b0);
    chk("sub_10_01_out", obs, {4'b1000, 8'h0F});
    do_op("sbc_00_00", 2'b11, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("sbc_00_00_out", obs, {4'b0010, 8'hFF});
    do_op("poke", 2'b00, 8'h3A, 8'h47, 1'b0, 1'b1);
    chk("poke_out", obs, {1'b0, 1'b0, 1'b1, OVF, 8'h81});

    // Async reset one step into CALC; previous result is nonzero.
    do_op("pre_rst", 2'b11, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    op = 2'b00; a = 8'h55; b = 8'h22; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_calc_reset", {busy, valid, cur_out()}, 14'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 2'b00, 8'h01, 8'h01, 1'b0, 1'b0);
    chk("after_rst_out", obs, {4'b0000, 8'h02});

    for (int i = 0; i < 1200; i++) begin
      ro = 2'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (i % 16 == 0) ra = 8'hFF;
      if (i % 16 == 1) rb = 8'h00;
      if (i % 16 == 2) begin ra = 8'h80; rb = 8'h7F; end
      do_op("rnd", ro, ra, rb, rc, (i % 7) == 0);
      chk("rnd_out", obs, ref_alu(ro, ra, rb, rc));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
